// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants for the load/store path.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half from a word and sign/zero-extends it per funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b   = word[8*lane +: 8];
        h   = lane[1] ? word[31:16] : word[15:0];
        ext = funct3 == F3_B  ? {{(XLEN-8){b[7]}}, b} :
              funct3 == F3_BU ? {{(XLEN-8){1'b0}}, b} :
              funct3 == F3_H  ? {{(XLEN-16){h[15]}}, h} :
              funct3 == F3_HU ? {{(XLEN-16){1'b0}}, h} :
              funct3 == F3_W  ? word : '0;
    end
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressable RV32I data memory; combinational loads, edge-committed stores,
// sticky fault flag for misaligned, out-of-range or illegal-width accesses.
module data_memory
    import riscv_pkg::*;
#(
    parameter int n      = 32,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] WriteData,
    output logic [n-1:0] ReadData,
    output logic         access_err,
    output logic         mem_fault
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [n-1:0]      mem_q [DEPTH];
    logic              mem_fault_q, mem_fault_d;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [n-1:0]      wrep, rd_word, word_d, ext;
    logic              oor, mis, illegal, ld_ok, st_ok, we;

    load_extend u_ext (
        .word   (rd_word),
        .lane   (lane),
        .funct3 (funct3),
        .ext    (ext)
    );

    always_comb begin
        widx        = addr[ADDR_W+1:2];
        lane        = addr[1:0];
        oor         = |addr[n-1:ADDR_W+2];
        mis         = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == F3_W && lane != 2'b00);
        ld_ok       = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_ok       = funct3 inside {F3_B, F3_H, F3_W};
        illegal     = (MemRead && !ld_ok) || (MemWrite && !st_ok);
        access_err  = (MemRead || MemWrite) && (oor || mis || illegal);
        we          = MemWrite && !access_err;
        be          = funct3 == F3_B ? 4'b0001 << lane :
                      funct3 == F3_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep        = funct3 == F3_B ? {4{WriteData[7:0]}} :
                      funct3 == F3_H ? {2{WriteData[15:0]}} : WriteData;
        rd_word     = mem_q[widx];
        word_d      = rd_word;
        for (int i = 0; i < 4; i++)
            word_d[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rd_word[8*i +: 8];
        mem_fault_d = mem_fault_q || access_err;
        ReadData    = (MemRead && !access_err) ? ext : '0;
        mem_fault   = mem_fault_q;
    end

    // Reset clears the whole array asynchronously, so a store in flight is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            if (we)
                mem_q[widx] <= word_d;
            mem_fault_q <= mem_fault_d;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: vector table + scoreboard check of loads, stores, faults and async reset.
module tb_data_memory;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, WriteData = '0;
    logic [31:0] ReadData;
    logic        access_err, mem_fault;

    int n_vec = 0, n_fail = 0;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    data_memory #(.n(32), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .WriteData(WriteData),
        .ReadData(ReadData), .access_err(access_err), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] er, logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.exp_rd = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        vec_t e;
        @(negedge clk);
        MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; addr = v.a; WriteData = v.wd;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        chk({nm, ".rd"}, ReadData, e.exp_rd);
        chk({nm, ".err"}, {31'b0, access_err}, {31'b0, e.exp_err});
    endtask

    task automatic idle_fault(input string nm, input logic exp);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk(nm, {31'b0, mem_fault}, {31'b0, exp});
    endtask

    initial begin
        #1;
        chk("reset.rd", ReadData, 32'h0);
        chk("reset.err", {31'b0, access_err}, 32'h0);
        chk("reset.fault", {31'b0, mem_fault}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk(1, 0, F3_W,  32'h00, 32'h0,        32'h00000000, 0));
        tbl.push_back(mk(0, 1, F3_W,  32'h10, 32'h80F1A2B3, 32'h00000000, 0));
        tbl.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        32'h80F1A2B3, 0));
        tbl.push_back(mk(1, 0, F3_B,  32'h13, 32'h0,        32'hFFFFFF80, 0));
        tbl.push_back(mk(1, 0, F3_BU, 32'h13, 32'h0,        32'h00000080, 0));
        tbl.push_back(mk(1, 0, F3_H,  32'h12, 32'h0,        32'hFFFF80F1, 0));
        tbl.push_back(mk(1, 0, F3_HU, 32'h10, 32'h0,        32'h0000A2B3, 0));
        tbl.push_back(mk(0, 1, F3_B,  32'h11, 32'h123456CC, 32'h00000000, 0));
        tbl.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        32'h80F1CCB3, 0));
        tbl.push_back(mk(1, 0, F3_B,  32'h11, 32'h0,        32'hFFFFFFCC, 0));
        tbl.push_back(mk(0, 1, F3_H,  32'h22, 32'hABCD7E55, 32'h00000000, 0));
        tbl.push_back(mk(1, 0, F3_W,  32'h20, 32'h0,        32'h7E550000, 0));
        tbl.push_back(mk(1, 0, F3_H,  32'h22, 32'h0,        32'h00007E55, 0));
        tbl.push_back(mk(1, 1, F3_W,  32'h10, 32'h11111111, 32'h80F1CCB3, 0));
        tbl.push_back(mk(1, 0, F3_W,  32'h10, 32'h0,        32'h11111111, 0));
        tbl.push_back(mk(0, 1, F3_W,  32'h3FC, 32'hA5A5A5A5, 32'h00000000, 0));
        tbl.push_back(mk(1, 0, F3_W,  32'h3FC, 32'h0,       32'hA5A5A5A5, 0));
        tbl.push_back(mk(0, 0, F3_W,  32'h401, 32'h0,       32'h00000000, 0));
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);
        idle_fault("fault.clean", 1'b0);

        apply("sw_mis",  mk(0, 1, F3_W, 32'h12, 32'hFFFFFFFF, 32'h0, 1));
        idle_fault("fault.set", 1'b1);
        apply("lw_after_mis", mk(1, 0, F3_W, 32'h10, 32'h0, 32'h11111111, 0));
        apply("sw_oor",  mk(0, 1, F3_W, 32'h400, 32'h1, 32'h0, 1));
        apply("lw0_after_oor", mk(1, 0, F3_W, 32'h0, 32'h0, 32'h0, 0));
        apply("lh_mis",  mk(1, 0, F3_H, 32'h11, 32'h0, 32'h0, 1));
        apply("ld_ill",  mk(1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1));
        apply("st_ill",  mk(0, 1, F3_BU, 32'h10, 32'h0, 32'h0, 1));
        apply("lw_after_ill", mk(1, 0, F3_W, 32'h10, 32'h0, 32'h11111111, 0));
        idle_fault("fault.sticky", 1'b1);

        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b1; funct3 = F3_W; addr = 32'h20; WriteData = 32'hDEADBEEF;
        #1;
        chk("rst_mid.pre", ReadData, 32'h7E550000);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.rd", ReadData, 32'h0);
        chk("rst_mid.fault", {31'b0, mem_fault}, 32'h0);
        @(posedge clk);
        #1 MemRead = 1'b0; MemWrite = 1'b0;
        #1 rst_n = 1'b1;
        apply("lw20_after_rst", mk(1, 0, F3_W, 32'h20, 32'h0, 32'h0, 0));
        apply("lw10_after_rst", mk(1, 0, F3_W, 32'h10, 32'h0, 32'h0, 0));
        idle_fault("fault.after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
